uart_rx_pkt_ctrl: RTL and testbench

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_pkt_buffer.sv | 21 ++
 rtl/uart_rx_pkt_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet receive path.
package uart_pkg;
    typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CHECK, ST_DRAIN} state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         CHK_W             = 8;
endpackage

// File: rtl/uart_pkt_buffer.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module uart_pkt_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          uart_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge uart_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Addresses past DEPTH can only appear when the read result is unused.
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : 8'h00;
endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames SYNC/LEN/payload/CHK byte streams from a UART receiver, verifies the
// checksum and drains the buffered payload over a valid/ready interface.
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int          MAX_LEN        = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic       uart_clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic       err_length,
    output logic       err_checksum,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state_q, state_d;
    logic [7:0]           len_q, len_d;
    logic [CHK_W-1:0]     sum_q, sum_d, sum_add;
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_addr;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 tmo_hit, buf_we;
    logic [7:0]           buf_rdata;
    logic [7:0]           pkt_data_d;
    logic                 pkt_valid_d, pkt_last_d, busy_d;
    logic                 err_length_d, err_checksum_d, err_timeout_d, err_overrun_d;

    uart_pkt_buffer #(.DEPTH(MAX_LEN), .AW(IDX_W)) u_buf (
        .uart_clk (uart_clk),
        .we       (buf_we),
        .waddr    (wr_idx_q),
        .wdata    (rx_data),
        .raddr    (rd_addr),
        .rdata    (buf_rdata)
    );

    assign sum_add = sum_q + rx_data;
    // Fires on the idle edge that would bring the counter to TIMEOUT_CYCLES.
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rd_addr = (state_q == ST_CHECK) ? '0 : rd_idx_q + IDX_W'(1);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        sum_d          = sum_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        tmo_d          = '0;
        buf_we         = 1'b0;
        pkt_data_d     = pkt_data;
        pkt_valid_d    = pkt_valid;
        pkt_last_d     = pkt_last;
        err_length_d   = 1'b0;
        err_checksum_d = 1'b0;
        err_timeout_d  = 1'b0;
        err_overrun_d  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        err_length_d = 1'b1;
                        state_d      = ST_HUNT;
                    end else begin
                        len_d    = rx_data;
                        sum_d    = rx_data;
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    buf_we   = 1'b1;
                    sum_d    = sum_add;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (8'(wr_idx_q) == len_q - 8'd1) state_d = ST_CHECK;
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (sum_add == '0) begin
                        rd_idx_d    = '0;
                        pkt_valid_d = 1'b1;
                        pkt_data_d  = buf_rdata;
                        pkt_last_d  = (len_q == 8'd1);
                        state_d     = ST_DRAIN;
                    end else begin
                        err_checksum_d = 1'b1;
                        state_d        = ST_HUNT;
                    end
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DRAIN: begin
                err_overrun_d = rx_valid;
                if (pkt_valid && pkt_ready) begin
                    if (pkt_last) begin
                        pkt_valid_d = 1'b0;
                        pkt_last_d  = 1'b0;
                        state_d     = ST_HUNT;
                    end else begin
                        rd_idx_d   = rd_idx_q + IDX_W'(1);
                        pkt_data_d = buf_rdata;
                        pkt_last_d = (8'(rd_idx_q) + 8'd1 == len_q - 8'd1);
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        busy_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge uart_clk) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            len_q        <= '0;
            sum_q        <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            tmo_q        <= '0;
            pkt_data     <= 8'h00;
            pkt_valid    <= 1'b0;
            pkt_last     <= 1'b0;
            err_length   <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            tmo_q        <= tmo_d;
            pkt_data     <= pkt_data_d;
            pkt_valid    <= pkt_valid_d;
            pkt_last     <= pkt_last_d;
            err_length   <= err_length_d;
            err_checksum <= err_checksum_d;
            err_timeout  <= err_timeout_d;
            err_overrun  <= err_overrun_d;
            busy         <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench: stimulus pushes expected payload bytes and error pulses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_uart_rx_pkt_ctrl;
    localparam int MAXL = 16;
    localparam int TMO  = 1024;

    localparam logic [3:0] E_LEN = 4'b1000;
    localparam logic [3:0] E_CHK = 4'b0100;
    localparam logic [3:0] E_TMO = 4'b0010;
    localparam logic [3:0] E_OVR = 4'b0001;

    logic       uart_clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic       err_length, err_checksum, err_timeout, err_overrun, busy;

    int checks = 0;
    int errors = 0;

    logic [8:0] dq[$];  // {last, data}
    logic [3:0] eq[$];  // {len, chk, tmo, ovr}
    logic       mon_en = 1'b0;
    logic       hold_v = 1'b0;
    logic [8:0] hold_d = '0;

    uart_rx_pkt_ctrl #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
        .uart_clk     (uart_clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .pkt_data     (pkt_data),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_last     (pkt_last),
        .err_length   (err_length),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .busy         (busy)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge uart_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] chk_b,
                              input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        logic [7:0] p [3];
        p[0] = p0; p[1] = p1; p[2] = p2;
        send(8'hA5);
        send(len);
        for (int i = 0; i < int'(len); i++) send(p[i]);
        send(chk_b);
    endtask

    always @(negedge uart_clk) begin
        if (mon_en) begin
            logic [3:0] errs;
            logic [3:0] ee;
            logic [8:0] de;
            errs = {err_length, err_checksum, err_timeout, err_overrun};
            if (errs != 4'b0) begin
                chk("err_onehot", $countones(errs), 1);
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: got %b expected none", errs);
                end else begin
                    ee = eq.pop_front();
                    chk("err_kind", errs, ee);
                end
            end
            if (hold_v) chk("hold_stable", {pkt_valid, pkt_last, pkt_data}, {1'b1, hold_d});
            if (pkt_valid && pkt_ready) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_xfer: got %0h expected none", pkt_data);
                end else begin
                    de = dq.pop_front();
                    chk("xfer_data_last", {pkt_last, pkt_data}, de);
                end
            end
            hold_v = pkt_valid && !pkt_ready;
            hold_d = {pkt_last, pkt_data};
        end
    end

    initial begin
        reset_n   = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        pkt_ready = 1'b1;
        idle(3);
        chk("reset_flags", {pkt_valid, pkt_last, err_length, err_checksum, err_timeout, err_overrun, busy}, 0);
        chk("reset_data", pkt_data, 8'h00);
        reset_n = 1'b1;
        idle(2);
        mon_en = 1'b1;

        // Basic frame, full-rate consumer
        dq.push_back({1'b0, 8'h11}); dq.push_back({1'b0, 8'h22}); dq.push_back({1'b1, 8'h33});
        send_frame(8'h03, 8'h97, 8'h11, 8'h22, 8'h33);
        chk("valid_latency", pkt_valid, 1);
        chk("busy_drain", busy, 1);
        idle(3);
        chk("drain_done_valid", pkt_valid, 0);
        chk("drain_done_busy", busy, 0);

        // Bad checksum
        eq.push_back(E_CHK);
        send_frame(8'h03, 8'h98, 8'h11, 8'h22, 8'h33);
        chk("chk_err_pulse", err_checksum, 1);
        chk("chk_err_busy", busy, 0);
        chk("chk_err_novalid", pkt_valid, 0);
        idle(1);
        chk("chk_err_single", err_checksum, 0);

        // Illegal lengths: zero and MAX_LEN+1
        eq.push_back(E_LEN);
        send(8'hA5); send(8'h00);
        chk("len0_err", err_length, 1);
        chk("len0_busy", busy, 0);
        eq.push_back(E_LEN);
        send(8'hA5); send(8'h11);
        chk("len17_err", err_length, 1);
        chk("len17_busy", busy, 0);
        idle(1);

        // Max length frame: bytes 1..16, CHK 68
        for (int i = 1; i <= MAXL; i++) dq.push_back({(i == MAXL), 8'(i)});
        send(8'hA5); send(8'h10);
        for (int i = 1; i <= MAXL; i++) send(8'(i));
        send(8'h68);
        chk("maxlen_valid", pkt_valid, 1);
        idle(MAXL + 1);
        chk("maxlen_done", busy, 0);

        // Inter-byte timeout, exact cycle
        eq.push_back(E_TMO);
        send(8'hA5); send(8'h02); send(8'h11);
        idle(TMO - 1);
        chk("tmo_not_early", err_timeout, 0);
        idle(1);
        chk("tmo_fire", err_timeout, 1);
        chk("tmo_busy", busy, 0);
        dq.push_back({1'b1, 8'h44});
        send(8'hA5); send(8'h01); send(8'h44); send(8'hBB);
        idle(2);
        chk("len1_done", pkt_valid, 0);

        // Byte on the timeout edge wins
        dq.push_back({1'b0, 8'h22}); dq.push_back({1'b1, 8'h33});
        send(8'hA5); send(8'h02);
        idle(TMO - 1);
        send(8'h22);
        chk("tmo_byte_wins", err_timeout, 0);
        chk("tmo_byte_busy", busy, 1);
        send(8'h33); send(8'hA9);
        idle(3);

        // Stalled drain with an overrun byte
        pkt_ready = 1'b0;
        dq.push_back({1'b0, 8'h11}); dq.push_back({1'b0, 8'h22}); dq.push_back({1'b1, 8'h33});
        eq.push_back(E_OVR);
        send_frame(8'h03, 8'h97, 8'h11, 8'h22, 8'h33);
        idle(2);
        send(8'h55);
        chk("overrun_pulse", err_overrun, 1);
        chk("stall_data", {pkt_valid, pkt_data}, {1'b1, 8'h11});
        idle(2);
        pkt_ready = 1'b1;
        idle(5);
        chk("stall_done", pkt_valid, 0);

        // Reset in the middle of a payload
        send(8'hA5); send(8'h03); send(8'h11);
        reset_n = 1'b0;
        idle(1);
        chk("midreset_flags", {pkt_valid, pkt_last, err_length, err_checksum, err_timeout, err_overrun, busy}, 0);
        chk("midreset_data", pkt_data, 8'h00);
        reset_n = 1'b1;
        idle(2);
        dq.push_back({1'b1, 8'h44});
        send(8'hA5); send(8'h01); send(8'h44); send(8'hBB);
        chk("post_reset_valid", pkt_valid, 1);
        idle(5);

        chk("data_queue_empty", dq.size(), 0);
        chk("err_queue_empty", eq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
